// File: rtl/mii_pattern_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mii_gen_pkg
// Description : Shared types and constants for the MII pattern generator:
//               FSM state encoding, default lane patterns, phase-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mii_gen_pkg;

    // Generator state; also names what is currently on the output bus
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CTRL = 2'd2
    } state_t;

    localparam logic [7:0] C_DEFAULT_DATA_CHAR = 8'hAA;
    localparam logic [7:0] C_DEFAULT_CTRL_CHAR = 8'h55;
    localparam logic [7:0] C_ERR_MASK          = 8'h01;

    // Words still to come after the first word of a DATA phase.
    // A zero length is treated as a one-word phase.
    function automatic logic [15:0] data_remaining(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : (len - 16'd1);
    endfunction

endpackage : mii_gen_pkg
`default_nettype wire

// File: rtl/mii_pattern_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : mii_pattern_generator_if
// Description : Control and data bus of the MII pattern generator. The
//               master side drives the controls and observes the bus; the
//               slave side is the generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mii_pattern_generator_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int LANES = DATA_WIDTH / 8;

    logic                  i_enable;
    logic [15:0]           i_data_len;
    logic [15:0]           i_ctrl_len;
    logic                  i_err_inject;
    logic [DATA_WIDTH-1:0] o_data;
    logic [LANES-1:0]      o_ctrl;
    logic [31:0]           o_word_count;
    logic [31:0]           o_err_count;
    logic                  o_busy;

    modport master (
        output i_enable, i_data_len, i_ctrl_len, i_err_inject,
        input  o_data, o_ctrl, o_word_count, o_err_count, o_busy
    );

    modport slave (
        input  i_enable, i_data_len, i_ctrl_len, i_err_inject,
        output o_data, o_ctrl, o_word_count, o_err_count, o_busy
    );

endinterface : mii_pattern_generator_if
`default_nettype wire

// File: rtl/mii_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : mii_pattern_generator
// Description : Emits alternating DATA / CTRL bursts of fixed byte patterns
//               on an MII-style bus, with optional single-word corruption
//               and running word / error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mii_pattern_generator
    import mii_gen_pkg::*;
#(
    parameter int         DATA_WIDTH        = 64,
    parameter logic [7:0] DATA_CHAR_PATTERN = C_DEFAULT_DATA_CHAR,
    parameter logic [7:0] CTRL_CHAR_PATTERN = C_DEFAULT_CTRL_CHAR
) (
    input  wire logic clk,
    input  wire logic rst,
    mii_pattern_generator_if.slave bus
);

    localparam int LANES = DATA_WIDTH / 8;

    // state_q always describes the word currently on the outputs
    state_t                state_q,      state_d;
    logic [15:0]           phase_cnt_q,  phase_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,       data_d;
    logic [LANES-1:0]      ctrl_q,       ctrl_d;
    logic [31:0]           word_count_q, word_count_d;
    logic [31:0]           err_count_q,  err_count_d;

    // Next state, phase counter and the next output word
    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        data_d       = '0;
        ctrl_d       = '0;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;

        // phase_cnt holds the number of words left in the phase after the
        // one currently displayed; lengths are latched only on phase entry
        case (state_q)
            IDLE: begin
                if (bus.i_enable) begin
                    state_d     = DATA;
                    phase_cnt_d = data_remaining(bus.i_data_len);
                end
            end
            DATA: begin
                if (!bus.i_enable) begin
                    state_d     = IDLE;
                    phase_cnt_d = '0;
                end else if (phase_cnt_q != 16'd0) begin
                    phase_cnt_d = phase_cnt_q - 16'd1;
                end else if (bus.i_ctrl_len == 16'd0) begin
                    // No control phase: start another DATA phase directly
                    phase_cnt_d = data_remaining(bus.i_data_len);
                end else begin
                    state_d     = CTRL;
                    phase_cnt_d = bus.i_ctrl_len - 16'd1;
                end
            end
            CTRL: begin
                if (!bus.i_enable) begin
                    state_d     = IDLE;
                    phase_cnt_d = '0;
                end else if (phase_cnt_q != 16'd0) begin
                    phase_cnt_d = phase_cnt_q - 16'd1;
                end else begin
                    state_d     = DATA;
                    phase_cnt_d = data_remaining(bus.i_data_len);
                end
            end
            default: begin
                state_d     = IDLE;
                phase_cnt_d = '0;
            end
        endcase

        if (state_d == DATA) begin
            data_d = {LANES{DATA_CHAR_PATTERN}};
            ctrl_d = '0;
        end else if (state_d == CTRL) begin
            data_d = {LANES{CTRL_CHAR_PATTERN}};
            ctrl_d = '1;
        end

        // Corruption only applies to a word actually emitted; an inject
        // request arriving while heading to IDLE is discarded
        if (state_d != IDLE) begin
            word_count_d = word_count_q + 32'd1;
            if (bus.i_err_inject) begin
                data_d[7:0] = data_d[7:0] ^ C_ERR_MASK;
                err_count_d = err_count_q + 32'd1;
            end
        end
    end

    // State, counters and output word registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_cnt_q  <= '0;
            data_q       <= '0;
            ctrl_q       <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_ctrl       = ctrl_q;
    assign bus.o_word_count = word_count_q;
    assign bus.o_err_count  = err_count_q;
    assign bus.o_busy       = (state_q != IDLE);

endmodule : mii_pattern_generator
`default_nettype wire

// File: doc/mii_pattern_generator.md
MII_PATTERN_GENERATOR -- requirements
Module: mii_pattern_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 64: bus width in bits, multiple of 8; LANES = DATA_WIDTH/8.
REQ-002 Parameter DATA_CHAR_PATTERN, default 8'hAA: byte driven on every data lane.
REQ-003 Parameter CTRL_CHAR_PATTERN, default 8'h55: byte driven on every control lane.
REQ-004 Clocking SHALL use one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_enable  input  1  level; 1 = generate bursts, 0 = return to idle.
REQ-008 i_data_len  input  16  words per data phase.
REQ-009 i_ctrl_len  input  16  words per control phase.
REQ-010 i_err_inject  input  1  single-cycle request to corrupt one output word.
REQ-011 o_data  output  DATA_WIDTH  generated MII data bus, registered.
REQ-012 o_ctrl  output  LANES  per-byte control flags, registered; 1 = control lane.
REQ-013 o_word_count  output  32  non-idle words emitted.
REQ-014 o_err_count  output  32  corrupted words emitted.
REQ-015 o_busy  output  1  high when state is not IDLE.

Function
REQ-016 States SHALL be IDLE, DATA, CTRL.
REQ-017 IDLE: o_data = 0, o_ctrl = 0, no counter changes.
REQ-018 IDLE -> DATA at an edge where i_enable = 1; the first DATA word is visible the cycle after i_enable is first sampled high (1-cycle latency).
REQ-019 DATA words: every lane = DATA_CHAR_PATTERN, o_ctrl = all zeros.
REQ-020 CTRL words: every lane = CTRL_CHAR_PATTERN, o_ctrl = all ones.
REQ-021 Phase length: i_data_len / i_ctrl_len sampled on entry to the phase; later changes do not affect the phase in progress.
REQ-022 DATA lasts max(i_data_len,1) words, then -> CTRL; CTRL lasts i_ctrl_len words, then -> DATA.
REQ-023 i_ctrl_len = 0: CTRL is skipped; DATA phases follow back-to-back.
REQ-024 i_enable sampled 0 in DATA or CTRL: -> IDLE at that edge, mid-phase abort allowed; next output word is idle (zeros).
REQ-025 i_err_inject sampled 1 while the next state is DATA or CTRL: the word emitted at that edge has lane 0 XOR 8'h01; o_err_count += 1.
REQ-026 i_err_inject while the next state is IDLE SHALL be dropped, not queued.
REQ-027 i_err_inject held high SHALL corrupt every qualifying word, one count each.
REQ-028 o_word_count += 1 per emitted DATA or CTRL word, including corrupted ones.
REQ-029 Both counters SHALL be 32-bit unsigned and wrap from 32'hFFFFFFFF to 0 without saturation.
REQ-030 o_busy = 1 exactly in the cycles a DATA or CTRL word is on the outputs.

Reset
REQ-031 rst = 1 at an edge forces IDLE; o_data, o_ctrl, o_word_count, o_err_count = 0 and o_busy = 0; phase counter cleared.
REQ-032 rst takes priority over all inputs, including mid-phase; after release, generation restarts from a fresh DATA phase.

Structure
REQ-033 Package mii_gen_pkg SHALL hold the state_t enum (IDLE, DATA, CTRL) and the default pattern constants 8'hAA / 8'h55.
REQ-034 No sub-module; one 16-bit down-counter for phase length, one FSM, registered outputs.

Verification
REQ-035 rst released, i_enable = 0 for 10 cycles -> o_data = 0, o_ctrl = 0, both counters = 0.
REQ-036 DATA_WIDTH = 64, data_len = 3, ctrl_len = 2, enable held -> sequence AAAAAAAAAAAAAAAA/00 x3, then 5555555555555555/FF x2, repeating; o_word_count = 10 after two full cycles.
REQ-037 ctrl_len = 0, data_len = 0 -> continuous DATA words, o_ctrl never nonzero, one word per cycle counted.
REQ-038 err_inject pulsed during second DATA word -> that word = AAAAAAAAAAAAAAAB; o_err_count = 1; err_inject pulsed while idle -> no change.
REQ-039 enable dropped in the middle of a 5-word CTRL phase -> next word zeros, o_busy = 0; re-enable -> fresh full DATA phase.
REQ-040 Preload o_word_count near 32'hFFFFFFFE via forced state, emit 3 words -> reads 1; rst mid-phase -> all outputs 0 next cycle.
